// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage, registered carry between stages.
// Optional clamp of the result on overflow: define PIPELINED_CSEL_ADDER_SATURATE_EN.
module pipelined_csel_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_c;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic              st_sub [STAGES];
  logic              st_sm  [STAGES];
  logic              ovf_q;

  logic [WIDTH-1:0]  nx_a   [STAGES];
  logic [WIDTH-1:0]  nx_b   [STAGES];
  logic [WIDTH-1:0]  nx_sum [STAGES];
  logic              nx_sub [STAGES];
  logic              nx_sm  [STAGES];
  logic [STAGES-1:0] nx_c;
  logic [SEG:0]      r0;
  logic [SEG:0]      r1;
  logic [WIDTH-1:0]  fin_sum;
  logic              nx_ovf;
  logic              adv;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] s;
    logic           c;
    c = ci;
    s = '0;
    for (int i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = st_valid[LAST];
  assign sum       = st_sum[LAST];
  assign cout      = st_c[LAST];
  assign overflow  = ovf_q;

  always_comb begin
    r0      = '0;
    r1      = '0;
    nx_c    = '0;
    fin_sum = '0;
    nx_ovf  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      nx_a[k]   = '0;
      nx_b[k]   = '0;
      nx_sum[k] = '0;
      nx_sub[k] = 1'b0;
      nx_sm[k]  = 1'b0;
    end

    // Stage 0 selects its candidate with the operation's carry-in (1 for subtract).
    nx_a[0]   = a;
    nx_b[0]   = sub ? ~b : b;
    nx_sub[0] = sub;
    nx_sm[0]  = signed_mode;
    r0 = seg_add(a[SEG-1:0], nx_b[0][SEG-1:0], 1'b0);
    r1 = seg_add(a[SEG-1:0], nx_b[0][SEG-1:0], 1'b1);
    nx_sum[0][SEG-1:0] = sub ? r1[SEG-1:0] : r0[SEG-1:0];
    nx_c[0]            = sub ? r1[SEG] : r0[SEG];

    for (int k = 1; k < STAGES; k++) begin
      nx_a[k]   = st_a[k-1];
      nx_b[k]   = st_b[k-1];
      nx_sub[k] = st_sub[k-1];
      nx_sm[k]  = st_sm[k-1];
      r0 = seg_add(nx_a[k][k*SEG +: SEG], nx_b[k][k*SEG +: SEG], 1'b0);
      r1 = seg_add(nx_a[k][k*SEG +: SEG], nx_b[k][k*SEG +: SEG], 1'b1);
      nx_sum[k]               = st_sum[k-1];
      nx_sum[k][k*SEG +: SEG] = st_c[k-1] ? r1[SEG-1:0] : r0[SEG-1:0];
      nx_c[k]                 = st_c[k-1] ? r1[SEG] : r0[SEG];
    end

    if (nx_sm[LAST])
      nx_ovf = (nx_a[LAST][WIDTH-1] == nx_b[LAST][WIDTH-1]) &
               (nx_sum[LAST][WIDTH-1] != nx_a[LAST][WIDTH-1]);
    else
      nx_ovf = nx_sub[LAST] ? ~nx_c[LAST] : nx_c[LAST];

    fin_sum = nx_sum[LAST];
`ifdef PIPELINED_CSEL_ADDER_SATURATE_EN
    if (nx_ovf) begin
      if (nx_sm[LAST])
        fin_sum = nx_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        fin_sum = nx_sub[LAST] ? '0 : '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_c     <= '0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
        st_sub[k] <= 1'b0;
        st_sm[k]  <= 1'b0;
      end
    end else if (adv) begin
      st_valid[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        st_valid[k] <= st_valid[k-1];
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= nx_a[k];
        st_b[k]   <= nx_b[k];
        st_sum[k] <= (k == LAST) ? fin_sum : nx_sum[k];
        st_sub[k] <= nx_sub[k];
        st_sm[k]  <= nx_sm[k];
      end
      st_c  <= nx_c;
      ovf_q <= nx_ovf;
    end
  end

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the convolution datapath (accumulator and partial-sum reduction stages).
- Splits a WIDTH-bit operation into STAGES equal segments, one segment per pipeline stage.
- Each segment precomputes both carry-in candidates and selects with the registered carry from the stage before.
- Adds subtract, signed/unsigned overflow detection and a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages = segments; SEG = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1: A-B, 0: A+B
- signed_mode  input  1  1: two's-complement overflow rules, 0: unsigned
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  raw carry out of the MSB
- overflow  output  1  overflow/underflow flag for the selected mode

Behaviour:
- One clock, single clock domain. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset: all stage valid bits, out_valid, sum, cout and overflow are 0. in_ready is 1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight transactions; none reappear.
- Effective operand: b_eff = sub ? ~b : b; carry-in = sub.
- Stage k (k = 0..STAGES-1) handles bits [k*SEG +: SEG]:
  - Computes seg_a + seg_b_eff + 0 and seg_a + seg_b_eff + 1 in parallel (ripple full adders per segment).
  - Selects using the carry registered by stage k-1; stage 0 uses the carry-in.
  - Registers the selected bits plus the segment carry.
- Unprocessed upper operand bits and the sub/signed_mode bits travel alongside each transaction through the stage registers. Lower result bits are also carried forward.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls.
- Throughput: one transaction per cycle.
- Advance: adv = out_ready | ~out_valid. in_ready = adv. When adv = 0 every stage register holds its value. Bubbles are not collapsed.
- Handshake:
  - in_valid=1 while in_ready=0: the operands are not captured; the source must hold them.
  - out_valid, sum, cout and overflow stay stable while out_valid & ~out_ready.
- cout = carry out of bit WIDTH-1, unchanged by mode.
- overflow:
  - unsigned add: cout.
  - unsigned sub: ~cout (borrow).
  - signed: (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
- Result is modulo 2^WIDTH when saturation is not compiled in.
- STAGES=1: purely registered single-cycle adder, latency 1.

Optional Feature:
- Macro: PIPELINED_CSEL_ADDER_SATURATE_EN.
- Defined: when overflow=1, sum is clamped instead of wrapping:
  - unsigned add: all ones.
  - unsigned sub: 0.
  - signed: 0111..1 if a[MSB]=0, else 1000..0.
  - overflow and cout are still reported as computed.
  - Clamping is applied in the final stage only; latency does not change.
- Undefined: no clamp logic is present; sum wraps.

Test Plan (WIDTH=32, STAGES=4):
- Reset then single add a=0x0000_FFFF, b=0x0000_0001, sub=0, signed_mode=0 -> out_valid exactly 4 cycles after acceptance; sum=0x0001_0000, cout=0, overflow=0 (carry crosses the segment boundary at bit 8/16).
- Unsigned wrap: a=0xFFFF_FFFF, b=0x1 -> sum=0x0, cout=1, overflow=1. With SATURATE_EN: sum=0xFFFF_FFFF.
- Signed sub: a=0x8000_0000, b=0x1, sub=1, signed_mode=1 -> sum=0x7FFF_FFFF, overflow=1. With SATURATE_EN: sum=0x8000_0000.
- Backpressure: stream 8 back-to-back random transactions, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the hold; output held stable; all 8 results appear in order, matching the reference model, with none lost or duplicated.
- Reset mid-stream: issue 3 transactions, assert rst_n=0 for 1 cycle at cycle 2 -> out_valid=0, sum=0 next cycle; no stale results afterwards. A fresh add 5+7 yields 12 after 4 cycles.
- Parameter sweep: (WIDTH,STAGES) = (16,1), (16,4), (64,8) with 1000 random add/sub, signed/unsigned vectors -> sum/cout/overflow match the reference model; latency equals STAGES.
